// File: rtl/axi_rd_arb.sv
`default_nettype none
// ============================================================================
// axi_rd_arb : round-robin arbiter sharing one AXI read channel, one burst at a time
// Revision   : 1.0 - initial release
// ============================================================================
module axi_rd_arb #(
  parameter int nreq = 4,
  parameter int aw   = 64,
  parameter int dw   = 64,
  localparam int iw  = $clog2(nreq)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [nreq-1:0]          s_arvalid,
  output logic [nreq-1:0]          s_arready,
  input  logic [nreq-1:0][aw-1:0]  s_araddr,
  input  logic [nreq-1:0][7:0]     s_arlen,
  input  logic [nreq-1:0][2:0]     s_arsize,
  input  logic [nreq-1:0][1:0]     s_arburst,
  output logic [nreq-1:0]          s_rvalid,
  input  logic [nreq-1:0]          s_rready,
  output logic [dw-1:0]            s_rdata,
  output logic [1:0]               s_rresp,
  output logic                     s_rlast,
  output logic [aw-1:0]            m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [dw-1:0]            m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rlast,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  output logic                     busy,
  output logic [iw-1:0]            gnt,
  output logic                     err
);

  localparam int iwp = iw + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state;
  logic [iw-1:0]    ptr;
  logic [8:0]       cnt;
  logic [7:0]       len;
  logic [iw-1:0]    pick;
  logic [2*nreq-1:0] rot;
  logic [iw:0]      sum;
  logic             ar_hs;
  logic             r_hs;

  // Rotate the request vector so bit 0 is the requester at ptr; the lowest
  // set bit is then the round-robin winner, offset back by ptr modulo nreq.
  always_comb begin
    rot = {s_arvalid, s_arvalid} >> ptr;
    sum = '0;
    for (int i = nreq - 1; i >= 0; i--) begin
      if (rot[i]) sum = {1'b0, ptr} + iwp'(i);
    end
    pick = (sum >= iwp'(nreq)) ? iw'(sum - iwp'(nreq)) : iw'(sum);
  end

  assign ar_hs = (state == ADDR) && s_arvalid[gnt] && m_axi_arready;
  assign r_hs  = (state == DATA) && m_axi_rvalid && s_rready[gnt];

  always_comb begin
    s_arready     = '0;
    s_rvalid      = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    if (state == ADDR) begin
      m_axi_arvalid  = s_arvalid[gnt];
      s_arready[gnt] = m_axi_arready;
    end
    if (state == DATA) begin
      s_rvalid[gnt] = m_axi_rvalid;
      m_axi_rready  = s_rready[gnt];
    end
  end

  assign m_axi_araddr  = s_araddr[gnt];
  assign m_axi_arlen   = s_arlen[gnt];
  assign m_axi_arsize  = s_arsize[gnt];
  assign m_axi_arburst = s_arburst[gnt];

  assign s_rdata = m_axi_rdata;
  assign s_rresp = m_axi_rresp;
  assign s_rlast = m_axi_rlast;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      len   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_arvalid) begin
            gnt   <= pick;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            len   <= s_arlen[gnt];
            cnt   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            cnt <= cnt + 9'd1;
            // rlast must coincide exactly with the (len+1)-th beat
            if (m_axi_rlast != (cnt == {1'b0, len})) err <= 1'b1;
            if (m_axi_rlast) begin
              ptr   <= (gnt == iw'(nreq - 1)) ? '0 : gnt + iw'(1);
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
